// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes: one shared combinational S-box walks the 16 state
// bytes (byte 0 = MSB) one per clock, then presents the whole result with a done pulse.

module sbytes (
  input  logic [7:0] olddata,
  output logic [7:0] newdata
);
  logic [7:0] sq, inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0), then the affine map.
  always_comb begin
    sq  = olddata;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    newdata = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module sub_bytes_seq #(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] state_in,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] state_out
);
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               cnt, pos;
  logic                        last;
  logic [NUM_BYTES-1:0][7:0]   buffer, buffer_nxt;
  logic [7:0]                  old_byte, new_byte;

  // Byte 0 sits in the top slot of the packed array, so count from the top down.
  assign pos      = CW'(NUM_BYTES - 1) - cnt;
  assign last     = (cnt == CW'(NUM_BYTES - 1));
  assign old_byte = buffer[pos];

  sbytes u_sbox (
    .olddata (old_byte),
    .newdata (new_byte)
  );

  always_comb begin
    buffer_nxt      = buffer;
    buffer_nxt[pos] = new_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final byte lands on the same edge that publishes the result, hence buffer_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      buffer    <= '0;
      state_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          buffer <= state_in;
          cnt    <= '0;
        end
        SUB: begin
          buffer <= buffer_nxt;
          cnt    <= last ? '0 : cnt + CW'(1);
          if (last) state_out <= buffer_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: cycle-level behavioural model plus directed AES vectors.

module tb_sub_bytes_seq;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL63    = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] state_in = '0;
  logic         busy, done;
  logic [127:0] state_out;

  always #5 clk = ~clk;

  sub_bytes_seq #(.NUM_BYTES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox [256];

  // Model: cycles left in the operation (17 = SUB x16 + DONE), pending and published results.
  int           m_left = 0;
  logic [127:0] m_res  = '0;
  logic [127:0] m_out  = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox[s[8*i +: 8]];
    return r;
  endfunction

  // S-box from the generator-3 walk over GF(2^8), pairing each p with its inverse q.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_res;
    end else if (start) begin
      m_left <= 17;
      m_res  <= sub_state(state_in);
    end
  end

  always @(negedge clk) begin
    check("cyc_done", 128'(done), 128'(m_left == 1));
    check("cyc_busy", 128'(busy), 128'(m_left > 0));
    check("cyc_out", state_out, m_out);
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  // Call at a negedge while idle; returns at the first idle negedge after done.
  task automatic run_op(input logic [127:0] v, input logic [127:0] exp, input string name);
    int n;
    state_in = v;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check({name, "_lat"}, 128'(n + 1), 128'd17);
    check({name, "_out"}, state_out, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]   bin  [4];
    logic [7:0]   bexp [4];
    int           n;

    build_sbox();
    check("model_fips", sub_state(FIPS_IN), FIPS_OUT);
    check("model_zero", sub_state(128'h0), ALL63);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(128'h0, ALL63, "zero");

    // Asynchronous reset in the middle of the high phase with a nonzero result held.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out", state_out, 128'h0);
    check("arst_done", 128'(done), 128'h0);
    check("arst_busy", 128'(busy), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(FIPS_IN, FIPS_OUT, "fips");

    bin[0] = 8'h43; bexp[0] = 8'h1a;
    bin[1] = 8'hff; bexp[1] = 8'h16;
    bin[2] = 8'h74; bexp[2] = 8'h92;
    bin[3] = 8'h61; bexp[3] = 8'hef;
    for (int i = 0; i < 4; i++)
      run_op({bin[i], 120'h0}, {bexp[i], {15{8'h63}}}, $sformatf("byte0_%0d", i));

    // start held high; state_in changes mid-operation and is only seen by the next capture.
    state_in = FIPS_IN;
    start    = 1'b1;
    repeat (3) @(negedge clk);
    state_in = 128'h0;
    wait_done(n);
    check("hold_lat", 128'(n + 3), 128'd17);
    check("hold_out1", state_out, FIPS_OUT);
    wait_done(n);
    start = 1'b0;
    check("hold_gap", 128'(n), 128'd18);
    check("hold_out2", state_out, ALL63);
    @(negedge clk);

    // Reset while the counter sits at 7: no done pulse, result cleared.
    state_in = FIPS_IN;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", state_out, 128'h0);
    check("midrst_done", 128'(done), 128'h0);
    check("midrst_busy", 128'(busy), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(FIPS_IN, FIPS_OUT, "after_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
